// File: rtl/spi_mode_master_pkg.sv
// rtl/spi_mode_master_pkg.sv - FSM encodings, SPI mode constants and default sizes for spi_mode_master
package spi_mode_master_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_CS   = 4;
  localparam int DEF_CLKDIV_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Mode constants are {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - loadable down-counter giving a 1-cycle tick every (load_value+1) enabled cycles
module spi_half_tick #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         tick
);

  logic [W-1:0] reload;
  logic [W-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= load_value;
      count  <= load_value;
    end else if (en) begin
      count <= (count == '0) ? reload : count - 1'b1;
    end
  end

  // Tick marks the last cycle of each half-period, so the FSM acts on it at the following edge
  assign tick = en && (count == '0);

endmodule

// File: rtl/spi_mode_master.sv
// rtl/spi_mode_master.sv - four-mode SPI master with runtime SCLK divider and one-hot active-low chip selects
module spi_mode_master
  import spi_mode_master_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_CS   = DEF_NUM_CS,
  parameter int CLKDIV_W = DEF_CLKDIV_W,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic [CS_W-1:0]     cs_sel,
  input  logic [DATA_W-1:0]   tx_data,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  logic [2:0]        state;
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tick;
  logic              accept;
  logic              tick_en;
  logic              sample_on_rise;
  logic              sample_edge;

  assign accept  = start && (state == ST_IDLE);
  assign tick_en = (state == ST_LEAD) || (state == ST_XFER) || (state == ST_TRAIL);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // Rising SCLK is the sample edge when cpol ^ cpha == 0; every other edge drives mosi
  assign sample_on_rise = ({cpol_q, cpha_q} == SPI_MODE0) || ({cpol_q, cpha_q} == SPI_MODE3);
  assign sample_edge    = ((sclk == 1'b0) == sample_on_rise);

  spi_half_tick #(
    .W(CLKDIV_W)
  ) u_half_tick (
    .clock      (clock),
    .resetn     (resetn),
    .load       (accept),
    .load_value (clk_div),
    .en         (tick_en),
    .tick       (tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          sclk     <= cpol;
          mosi     <= 1'b0;
          cs_n     <= '1;
          edge_cnt <= '0;
          if (start) begin
            state  <= ST_LEAD;
            cpol_q <= cpol;
            cpha_q <= cpha;
            for (int i = 0; i < NUM_CS; i++) begin
              cs_n[i] <= (int'(cs_sel) != i);
            end
            // cpha=0 presents the MSB before the first edge; cpha=1 waits for the first leading edge
            if (cpha) begin
              tx_sr <= tx_data;
            end else begin
              mosi  <= tx_data[DATA_W-1];
              tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_LEAD: begin
          if (tick) state <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (edge_cnt == LAST_EDGE) state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            state   <= ST_DONE;
            rx_data <= rx_sr;
            cs_n    <= '1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          sclk  <= cpol_q;
          mosi  <= 1'b0;
          cs_n  <= '1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mode_master.sv
// tb/tb_spi_mode_master.sv - randomized self-checking bench for spi_mode_master against a behavioural SPI slave
module tb_spi_mode_master;
  localparam int DATA_W   = 16;
  localparam int NUM_CS   = 4;
  localparam int CLKDIV_W = 8;

  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic miso;
  logic [CLKDIV_W-1:0] clk_div = '0;
  logic [1:0] cs_sel = '0;
  logic [DATA_W-1:0] tx_data = '0;
  logic busy, done, sclk, mosi;
  logic [DATA_W-1:0] rx_data;
  logic [NUM_CS-1:0] cs_n;
  logic busy3, done3, sclk3, mosi3;
  logic [DATA_W-1:0] rx3;
  logic [2:0] cs_n3;
  int n_cmp = 0, n_fail = 0;

  always #5 clock = ~clock;

  spi_mode_master #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .CLKDIV_W(CLKDIV_W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .cs_sel(cs_sel), .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n));

  // Three-select twin: same stimulus, so cs_sel=3 exercises the out-of-range select rule
  spi_mode_master #(.DATA_W(DATA_W), .NUM_CS(3), .CLKDIV_W(CLKDIV_W)) dut3 (
    .clock(clock), .resetn(resetn), .start(start), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .cs_sel(cs_sel), .tx_data(tx_data), .busy(busy3), .done(done3), .rx_data(rx3),
    .sclk(sclk3), .mosi(mosi3), .miso(miso), .cs_n(cs_n3));

  // Behavioural SPI slave: leading edge leaves the idle level, trailing edge returns to it
  logic [DATA_W-1:0] slv_word = '0, slv_tx = '0, slv_rx = '0;
  logic slv_cpol = 1'b0, slv_cpha = 1'b0, slv_miso = 1'b0, slv_sclk_q = 1'b0, loopback = 1'b0;
  int slv_arm = 0, slv_seen = 0;

  assign miso = loopback ? mosi : slv_miso;

  always @(sclk or slv_arm) begin
    if (slv_arm != slv_seen) begin
      slv_seen = slv_arm;
      slv_tx   = slv_word;
      slv_rx   = '0;
      slv_miso = slv_cpha ? 1'b0 : slv_word[DATA_W-1];
    end else if (sclk !== slv_sclk_q) begin
      if (sclk !== slv_cpol) begin
        if (slv_cpha) begin
          slv_miso = slv_tx[DATA_W-1];
          slv_tx   = slv_tx << 1;
        end else begin
          slv_rx = {slv_rx[DATA_W-2:0], mosi};
        end
      end else begin
        if (slv_cpha) begin
          slv_rx = {slv_rx[DATA_W-2:0], mosi};
        end else begin
          slv_tx   = slv_tx << 1;
          slv_miso = slv_tx[DATA_W-1];
        end
      end
    end
    slv_sclk_q = sclk;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    repeat (3) step();
  endtask

  // One full transfer; ends one cycle after the expected done cycle with busy expected low
  task automatic run_xfer(input string name, input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] sw,
                          input bit lb, input logic [CLKDIV_W-1:0] div, input logic [1:0] sel, input int poke);
    int h, exp_done, done_at, done3_at, n_done, rises, r1, r2, bad_cs, bad_mosi, bad_twin;
    logic [DATA_W-1:0] exp_rx, rx_seen, rx3_seen;
    logic [NUM_CS-1:0] exp_cs;
    logic [2:0] exp_cs3;
    logic busy1, busy_last, prev_sclk, prev_mosi;
    h = int'(div) + 1;
    exp_done = 1 + (2 * DATA_W + 2) * h;
    exp_rx = lb ? w : sw;
    exp_cs = '1;
    exp_cs[sel] = 1'b0;
    exp_cs3 = 3'b111;
    if (sel < 2'd3) exp_cs3[sel] = 1'b0;
    done_at = -1; done3_at = -1; n_done = 0; rises = 0; r1 = -1; r2 = -1;
    bad_cs = 0; bad_mosi = 0; bad_twin = 0; rx_seen = 'x; rx3_seen = 'x; busy1 = 1'b0; busy_last = 1'b0;

    n_cmp++;
    if (sclk !== cpol) begin n_fail++; $display("FAIL %s idle_sclk_before: got %b want %b", name, sclk, cpol); end

    slv_word = sw; slv_cpol = cpol; slv_cpha = cpha; loopback = lb; slv_arm++;
    tx_data = w; clk_div = div; cs_sel = sel; start = 1'b1;
    prev_sclk = sclk; prev_mosi = mosi;
    for (int c = 1; c <= exp_done + 1; c++) begin
      step();
      if (c == 1) begin start = 1'b0; busy1 = busy; end
      if (poke > 0 && c == poke) begin
        start = 1'b1; tx_data = ~w; cs_sel = sel + 2'd1; clk_div = div + 8'd1;
      end
      if (poke > 0 && c == poke + 1) start = 1'b0;
      if (c == exp_done) busy_last = busy;
      if (done) begin
        n_done++;
        if (done_at < 0) begin done_at = c; rx_seen = rx_data; rx3_seen = rx3; end
      end
      if (done3 && done3_at < 0) done3_at = c;
      if (c < exp_done && (cs_n !== exp_cs || cs_n3 !== exp_cs3)) bad_cs++;
      if (c >= exp_done && (cs_n !== '1 || cs_n3 !== 3'b111)) bad_cs++;
      if (sclk3 !== sclk || mosi3 !== mosi || busy3 !== busy) bad_twin++;
      if (sclk !== prev_sclk) begin
        if (sclk === 1'b1) begin
          rises++;
          if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
        end
        if (mosi !== prev_mosi && ((sclk !== cpol) != cpha)) bad_mosi++;
      end
      prev_sclk = sclk; prev_mosi = mosi;
    end

    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL %s busy_cycle1: got %b want 1", name, busy1); end
    n_cmp++; if (busy_last !== 1'b1) begin n_fail++; $display("FAIL %s busy_in_done: got %b want 1", name, busy_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done: got %b want 0", name, busy); end
    n_cmp++; if (done_at !== exp_done) begin n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, exp_done); end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, n_done); end
    n_cmp++; if (done3_at !== exp_done) begin n_fail++; $display("FAIL %s done_cycle_3cs: got %0d want %0d", name, done3_at, exp_done); end
    n_cmp++; if (rx_seen !== exp_rx) begin n_fail++; $display("FAIL %s rx_data: got %h want %h", name, rx_seen, exp_rx); end
    n_cmp++; if (rx3_seen !== exp_rx) begin n_fail++; $display("FAIL %s rx_data_3cs: got %h want %h", name, rx3_seen, exp_rx); end
    n_cmp++; if (slv_rx !== w) begin n_fail++; $display("FAIL %s slave_rx_mosi: got %h want %h", name, slv_rx, w); end
    n_cmp++; if (rises !== DATA_W) begin n_fail++; $display("FAIL %s sclk_rises: got %0d want %0d", name, rises, DATA_W); end
    n_cmp++; if (r2 - r1 !== 2 * h) begin n_fail++; $display("FAIL %s sclk_period: got %0d want %0d", name, r2 - r1, 2 * h); end
    n_cmp++; if (bad_cs !== 0) begin n_fail++; $display("FAIL %s cs_n_cycles_wrong: got %0d want 0", name, bad_cs); end
    n_cmp++; if (bad_mosi !== 0) begin n_fail++; $display("FAIL %s mosi_on_sample_edge: got %0d want 0", name, bad_mosi); end
    n_cmp++; if (bad_twin !== 0) begin n_fail++; $display("FAIL %s twin_diverged: got %0d want 0", name, bad_twin); end
    n_cmp++; if (sclk !== cpol) begin n_fail++; $display("FAIL %s idle_sclk_after: got %b want %b", name, sclk, cpol); end
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
    n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (cs_n !== 4'b1111) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1111", cs_n); end
    resetn = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_mode0_loopback();
    set_mode(1'b0, 1'b0);
    run_xfer("mode0_a5c3", 16'hA5C3, 16'h0000, 1'b1, 8'd0, 2'd0, 0);
    for (int i = 0; i < 3; i++)
      run_xfer("mode0_rand", DATA_W'($urandom), DATA_W'($urandom), 1'b1,
               CLKDIV_W'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 0);
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      set_mode(1'(m >> 1), 1'(m));
      run_xfer("mode_3c5a", DATA_W'($urandom), 16'h3C5A, 1'b0, 8'd0, 2'd1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      set_mode(1'($urandom), 1'($urandom));
      run_xfer("mode_rand", DATA_W'($urandom), DATA_W'($urandom), 1'($urandom),
               CLKDIV_W'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_clkdiv();
    set_mode(1'b0, 1'b0);
    run_xfer("clkdiv3", DATA_W'($urandom), DATA_W'($urandom), 1'b0, 8'd3, 2'd2, 0);
  endtask

  task automatic test_back_to_back();
    set_mode(1'b1, 1'b1);
    run_xfer("ignore_mid_start", DATA_W'($urandom), DATA_W'($urandom), 1'b0, 8'd1, 2'd0, 20);
    run_xfer("back_to_back", DATA_W'($urandom), DATA_W'($urandom), 1'b0, 8'd0, 2'd3, 0);
    run_xfer("back_to_back2", DATA_W'($urandom), DATA_W'($urandom), 1'b1, 8'd2, 2'd1, 0);
  endtask

  task automatic test_cs_out_of_range();
    set_mode(1'b0, 1'b1);
    run_xfer("cs_sel3_on_3cs", DATA_W'($urandom), DATA_W'($urandom), 1'b0, 8'd0, 2'd3, 0);
  endtask

  task automatic test_reset_mid();
    int rises, n_done;
    bit hit;
    logic prev;
    rises = 0; n_done = 0; hit = 0;
    set_mode(1'b0, 1'b0);
    tx_data = DATA_W'($urandom); clk_div = 8'd1; cs_sel = 2'd2; start = 1'b1;
    prev = sclk;
    for (int c = 1; c <= 200 && !hit; c++) begin
      step();
      start = 1'b0;
      if (done) n_done++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      if (rises == 7) hit = 1;
    end
    n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_bit7: got %0d rises want 7", rises); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (cs_n !== 4'b1111) begin n_fail++; $display("FAIL reset_mid_cs_n: got %b want 1111", cs_n); end
    n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_mid_sclk: got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    n_cmp++; if (cs_n3 !== 3'b111) begin n_fail++; $display("FAIL reset_mid_cs_n_3cs: got %b want 111", cs_n3); end
    repeat (3) begin step(); if (done) n_done++; end
    resetn = 1'b1;
    repeat (40) begin step(); if (done) n_done++; end
    n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d want 0", n_done); end
    run_xfer("after_reset", DATA_W'($urandom), DATA_W'($urandom), 1'b0, 8'd1, 2'd2, 0);
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_clkdiv();
    test_back_to_back();
    test_cs_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
